// File: rtl/bcd_scan_mux_pkg.sv
// Shared definitions for the multiplexed BCD display scanner.
// Holds the digit width, a constant-safe clog2 and the leading-zero mask helper.
package bcd_scan_mux_pkg;

  localparam int BCD_W   = 4;
  localparam int MAX_DIG = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Bit k set means digit k and every more-significant digit are zero; digit 0 never blanks.
  function automatic logic [MAX_DIG-1:0] lz_blank_mask(
    input logic [BCD_W*MAX_DIG-1:0] active,
    input int                       ndig
  );
    logic [MAX_DIG-1:0] mask;
    logic               all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int k = MAX_DIG - 1; k >= 1; k--) begin
      if (k < ndig) begin
        all_zero = all_zero && (active[k*BCD_W +: BCD_W] == '0);
        mask[k]  = all_zero;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/bcd_scan_mux_scan_prescaler.sv
// Slot timing for the display scanner: cnt runs 0..DIV-1 inside a slot,
// idx steps through the digits, boundary marks the last cycle of a frame.
module bcd_scan_mux_scan_prescaler
  import bcd_scan_mux_pkg::*;
#(
  parameter  int NDIG  = 4,
  parameter  int DIV   = 50000,
  parameter  int GUARD = 16,
  localparam int CNT_W = clog2(DIV),
  localparam int IDX_W = (NDIG > 1) ? clog2(NDIG) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             slot_start_o,
  output logic             guard_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             boundary_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             slot_end;
  logic             last_idx;

  assign slot_end = (cnt_q == CNT_W'(DIV - 1));
  assign last_idx = (idx_q == IDX_W'(NDIG - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // A zero-length guard must not produce a constant compare against 0.
  generate
    if (GUARD == 0) begin : gen_no_guard
      assign guard_o = 1'b0;
    end else begin : gen_guard
      assign guard_o = (cnt_q < CNT_W'(GUARD));
    end
  endgenerate

  assign slot_start_o = (cnt_q == '0);
  assign idx_o        = idx_q;
  assign boundary_o   = slot_end && last_idx;

endmodule

// File: rtl/bcd_scan_mux.sv
// Multi-digit common-anode scanner: shadow/active digit registers with a
// frame-aligned load handshake, leading-zero blanking and registered outputs.
module bcd_scan_mux
  import bcd_scan_mux_pkg::*;
#(
  parameter  int NDIG     = 4,
  parameter  int DIV      = 50000,
  parameter  int GUARD    = 16,
  parameter  int BLANK_LZ = 1,
  localparam int IDX_W    = (NDIG > 1) ? clog2(NDIG) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [BCD_W*NDIG-1:0] din,
  output logic [BCD_W-1:0]      bcd,
  output logic                  en,
  output logic [NDIG-1:0]       dig_n,
  output logic                  pending,
  output logic                  frame
);

  logic                  slot_start;
  logic                  guard;
  logic [IDX_W-1:0]      idx;
  logic                  boundary;

  logic [BCD_W*NDIG-1:0] shadow_q, shadow_d;
  logic [BCD_W*NDIG-1:0] active_q, active_d;
  logic                  pending_q, pending_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic                  en_q, en_d;
  logic [NDIG-1:0]       dig_n_q, dig_n_d;
  logic                  frame_q;

  logic [BCD_W-1:0]      digit [NDIG];
  logic [MAX_DIG-1:0]    mask_full;
  logic [NDIG-1:0]       blank;
  logic                  unused_ok;

  bcd_scan_mux_scan_prescaler #(
    .NDIG  (NDIG),
    .DIV   (DIV),
    .GUARD (GUARD)
  ) u_prescaler (
    .clk          (clk),
    .rst_n        (rst_n),
    .slot_start_o (slot_start),
    .guard_o      (guard),
    .idx_o        (idx),
    .boundary_o   (boundary)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : gen_digit
      assign digit[gi] = active_q[gi*BCD_W +: BCD_W];
    end
  endgenerate

  assign mask_full = lz_blank_mask((BCD_W*MAX_DIG)'(active_q), NDIG);

  generate
    if (BLANK_LZ != 0) begin : gen_blank
      assign blank = mask_full[NDIG-1:0];
    end else begin : gen_no_blank
      assign blank = '0;
    end
  endgenerate

  // A load in the boundary cycle goes straight to active and never raises pending.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (load) shadow_d = din;
    if (boundary) begin
      pending_d = 1'b0;
      if (load)           active_d = din;
      else if (pending_q) active_d = shadow_q;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    bcd_d   = digit[idx];
    en_d    = ~blank[idx];
    dig_n_d = guard ? '1 : ~(NDIG'(1) << idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      bcd_q     <= '0;
      en_q      <= 1'b0;
      dig_n_q   <= '1;
      frame_q   <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      bcd_q     <= bcd_d;
      en_q      <= en_d;
      dig_n_q   <= dig_n_d;
      frame_q   <= boundary;
    end
  end

  assign unused_ok = &{1'b0, slot_start, mask_full};

  assign bcd     = bcd_q;
  assign en      = en_q;
  assign dig_n   = dig_n_q;
  assign pending = pending_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Bench for bcd_scan_mux: per-frame slot expectations are queued as loads are
// scheduled and popped at the last cycle of each slot.
module tb_bcd_scan_mux;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = NDIG * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] din = 16'h0;

  logic [3:0]  bcd, bcd_nb;
  logic        en, en_nb;
  logic [3:0]  dig_n, dig_n_nb;
  logic        pending, pending_nb;
  logic        frame, frame_nb;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [3:0] bcd;
    logic       en;
    logic [3:0] dig_n;
  } exp_t;

  exp_t sb[$];

  bcd_scan_mux #(.NDIG(NDIG), .DIV(DIV), .GUARD(GUARD), .BLANK_LZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .din(din),
    .bcd(bcd), .en(en), .dig_n(dig_n), .pending(pending), .frame(frame)
  );

  bcd_scan_mux #(.NDIG(NDIG), .DIV(DIV), .GUARD(GUARD), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .load(load), .din(din),
    .bcd(bcd_nb), .en(en_nb), .dig_n(dig_n_nb), .pending(pending_nb), .frame(frame_nb)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // A digit is lit when it is digit 0 or anything from it upward is non-zero.
  task automatic push_frame(input logic [15:0] disp);
    exp_t e;
    for (int k = 0; k < NDIG; k++) begin
      e.bcd   = disp[4*k +: 4];
      e.en    = (k == 0) || ((disp >> (4 * k)) != 16'h0);
      e.dig_n = 4'(~(4'b0001 << k));
      sb.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".bcd"},     16'(bcd),     16'h0);
    check_val({tag, ".en"},      16'(en),      16'h0);
    check_val({tag, ".dig_n"},   16'(dig_n),   16'hF);
    check_val({tag, ".pending"}, 16'(pending), 16'h0);
    check_val({tag, ".frame"},   16'(frame),   16'h0);
  endtask

  // Runs one frame of FRAME cycles; loads at offsets lo0/lo1 (-1 = none).
  // abort_at >= 0 stops after that cycle and drops the remaining expectations.
  task automatic run_frame(input int fr, input logic [15:0] disp,
                           input int lo0, input logic [15:0] lv0,
                           input int lo1, input logic [15:0] lv1,
                           input int abort_at);
    logic pend;
    exp_t e;
    int   slot, phase;
    pend = 1'b0;
    push_frame(disp);
    for (int off = 0; off < FRAME; off++) begin
      @(negedge clk);
      load = (off == lo0) || (off == lo1);
      din  = (off == lo1) ? lv1 : (off == lo0) ? lv0 : 16'hDEAD;
      @(posedge clk);
      #1;
      if (off == FRAME - 1) pend = 1'b0;
      else if (load)        pend = 1'b1;
      slot  = off / DIV;
      phase = off % DIV;
      check_val($sformatf("f%0d.o%0d.pending", fr, off), 16'(pending), 16'(pend));
      check_val($sformatf("f%0d.o%0d.frame", fr, off), 16'(frame), 16'(off == FRAME - 1));
      if (phase < GUARD) begin
        check_val($sformatf("f%0d.o%0d.guard", fr, off), 16'(dig_n), 16'hF);
        check_val($sformatf("f%0d.o%0d.guard_nb", fr, off), 16'(dig_n_nb), 16'hF);
      end
      if (phase == DIV - 1) begin
        if (sb.size() == 0) begin
          check_val($sformatf("f%0d.s%0d.sb_empty", fr, slot), 16'h1, 16'h0);
        end else begin
          e = sb.pop_front();
          check_val($sformatf("f%0d.s%0d.bcd", fr, slot),      16'(bcd),      16'(e.bcd));
          check_val($sformatf("f%0d.s%0d.en", fr, slot),       16'(en),       16'(e.en));
          check_val($sformatf("f%0d.s%0d.dig_n", fr, slot),    16'(dig_n),    16'(e.dig_n));
          check_val($sformatf("f%0d.s%0d.bcd_nb", fr, slot),   16'(bcd_nb),   16'(e.bcd));
          check_val($sformatf("f%0d.s%0d.en_nb", fr, slot),    16'(en_nb),    16'h1);
          check_val($sformatf("f%0d.s%0d.dig_n_nb", fr, slot), 16'(dig_n_nb), 16'(e.dig_n));
          check_val($sformatf("f%0d.s%0d.pend_nb", fr, slot),  16'(pending_nb), 16'(pend));
          check_val($sformatf("f%0d.s%0d.frame_nb", fr, slot), 16'(frame_nb), 16'(off == FRAME - 1));
        end
      end
      if (off == abort_at) begin
        sb.delete();
        break;
      end
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    run_frame(0, 16'h0000,  3, 16'h1234, -1, 16'h0,    -1);
    run_frame(1, 16'h1234,  5, 16'h0050, -1, 16'h0,    -1);
    run_frame(2, 16'h0050,  5, 16'h0000, -1, 16'h0,    -1);
    run_frame(3, 16'h0000,  2, 16'h1111, -1, 16'h0,    -1);
    run_frame(4, 16'h1111, 20, 16'h9999, -1, 16'h0,    -1);
    run_frame(5, 16'h9999,  4, 16'h2222, 10, 16'h3333, -1);
    run_frame(6, 16'h3333, 31, 16'h4444, -1, 16'h0,    -1);
    run_frame(7, 16'h4444, -1, 16'h0,    -1, 16'h0,    -1);
    run_frame(8, 16'h4444,  3, 16'h5678, -1, 16'h0,    2 * DIV + 2);

    load  = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;

    run_frame(9, 16'h0000, -1, 16'h0, -1, 16'h0, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
